// File: rtl/bw_io_impctl_dn_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bw_io_impctl_dn_ctl                                                      |
// | Pull-down impedance calibration controller: settle/strobe/evaluate FSM,  |
// | vote filter and up/down code counter with lock and saturation flags.     |
// | Optional code freeze input enabled by BW_IO_IMPCTL_DNCTL_HOLD_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bw_io_impctl_dn_ctl #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned FILT       = 4,
  parameter int unsigned LOCK_TOG   = 3
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       cal_en,
  input  logic       above,
`ifdef BW_IO_IMPCTL_DNCTL_HOLD_EN
  input  logic       hold,
`endif
  output logic       sclk,
  output logic [8:1] cbd,
  output logic       dn_lock,
  output logic       dn_sat
);

  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] c_filt        = 4'(FILT);
  localparam logic [2:0] c_lock_tog    = 3'(LOCK_TOG);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EVAL   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_settle_cnt;
  logic       r_wait_cnt;
  logic [3:0] r_filt_cnt;
  logic [2:0] r_tog_cnt;
  logic       r_dir_last;
  logic       r_step_last;
  logic       r_first;

  logic       w_hold;
  logic       w_eval;
  logic       w_vote_same;
  logic [3:0] w_filt_inc;
  logic       w_step;
  logic       w_blocked;
  logic       w_rev;
  logic [2:0] w_tog_nxt;

`ifdef BW_IO_IMPCTL_DNCTL_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) r_state <= ST_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!cal_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (r_settle_cnt == c_settle_last) w_state_nxt = ST_STROBE;
        ST_STROBE: w_state_nxt = ST_WAIT;
        ST_WAIT:   if (r_wait_cnt) w_state_nxt = ST_EVAL;
        ST_EVAL:   w_state_nxt = ST_SETTLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The new vote direction is always the sampled comparator value; only the
  // run length depends on whether it agrees with the previous vote.
  assign w_eval      = cal_en && (r_state == ST_EVAL) && !w_hold;
  assign w_vote_same = (above == r_dir_last) && (r_filt_cnt != 4'd0);
  assign w_filt_inc  = w_vote_same ? (r_filt_cnt + 4'd1) : 4'd1;
  assign w_step      = w_eval && (w_filt_inc == c_filt);
  assign w_blocked   = above ? (cbd == 8'hFF) : (cbd == 8'h00);
  assign w_rev       = !r_first && (above != r_step_last);
  assign w_tog_nxt   = !w_rev ? 3'd0 :
                       (r_tog_cnt == c_lock_tog) ? r_tog_cnt : (r_tog_cnt + 3'd1);

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_settle_cnt <= 8'd0;
      r_wait_cnt   <= 1'b0;
    end else begin
      r_settle_cnt <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) ?
                      (r_settle_cnt + 8'd1) : 8'd0;
      r_wait_cnt   <= (r_state == ST_WAIT && w_state_nxt == ST_WAIT);
    end
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      sclk        <= 1'b0;
      cbd         <= 8'h80;
      dn_lock     <= 1'b0;
      dn_sat      <= 1'b0;
      r_filt_cnt  <= 4'd0;
      r_tog_cnt   <= 3'd0;
      r_dir_last  <= 1'b0;
      r_step_last <= 1'b0;
      r_first     <= 1'b1;
    end else begin
      sclk <= (w_state_nxt == ST_STROBE);
      if (!cal_en) begin
        // Code is deliberately kept so a restart resumes near the last trim.
        r_filt_cnt <= 4'd0;
        r_tog_cnt  <= 3'd0;
        dn_lock    <= 1'b0;
        dn_sat     <= 1'b0;
        r_first    <= 1'b1;
      end else if (w_eval) begin
        r_dir_last <= above;
        if (w_step) begin
          r_filt_cnt <= 4'd0;
          if (w_blocked) begin
            dn_sat <= 1'b1;
          end else begin
            cbd         <= above ? (cbd + 8'd1) : (cbd - 8'd1);
            dn_sat      <= 1'b0;
            r_tog_cnt   <= w_tog_nxt;
            r_step_last <= above;
            r_first     <= 1'b0;
            if (w_tog_nxt == c_lock_tog) dn_lock <= 1'b1;
          end
        end else begin
          r_filt_cnt <= w_filt_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire
